// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one finished execution unit
// per cycle and broadcasts its result on a registered CDB one cycle later.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int ROB_TAG_W = 4,
  parameter int PREG_W    = 6,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic [NUM_FU-1:0]           fu_valid_i,
  input  logic [NUM_FU*ROB_TAG_W-1:0] fu_tag_i,
  input  logic [NUM_FU*PREG_W-1:0]    fu_preg_i,
  input  logic [NUM_FU*DATA_W-1:0]    fu_data_i,
  input  logic [NUM_FU-1:0]           fu_mispredict_i,
  output logic [NUM_FU-1:0]           fu_ready_o,
  output logic                        cdb_valid_o,
  output logic [ROB_TAG_W-1:0]        cdb_tag_o,
  output logic [PREG_W-1:0]           cdb_preg_o,
  output logic [DATA_W-1:0]           cdb_data_o,
  output logic                        cdb_mispredict_o
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 r_cdb_valid;
  logic [ROB_TAG_W-1:0] r_cdb_tag;
  logic [PREG_W-1:0]    r_cdb_preg;
  logic [DATA_W-1:0]    r_cdb_data;
  logic                 r_cdb_mispredict;

  logic                 w_grant;
  logic [PTR_W-1:0]     w_winner;
  logic [PTR_W-1:0]     w_idx;
  logic [PTR_W-1:0]     w_next_ptr;

  // Scan from the round-robin pointer, wrapping, and keep the first valid unit.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_FU);
      if (!w_grant && fu_valid_i[w_idx]) begin
        w_grant  = 1'b1;
        w_winner = w_idx;
      end
    end
    if (rst || flush_i) begin
      w_grant = 1'b0;
    end
  end

  always_comb begin
    fu_ready_o = '0;
    if (w_grant) begin
      fu_ready_o = NUM_FU'(1) << w_winner;
    end
  end

  always_comb begin
    w_next_ptr = '0;
    if (int'(w_winner) != NUM_FU - 1) begin
      w_next_ptr = w_winner + PTR_W'(1);
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples the
  // pre-edge values regardless of statement order. The payload registers are
  // reset too, so the bus shows zeros rather than X until the first broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr         <= '0;
      r_cdb_valid      <= 1'b0;
      r_cdb_tag        <= '0;
      r_cdb_preg       <= '0;
      r_cdb_data       <= '0;
      r_cdb_mispredict <= 1'b0;
    end else if (w_grant) begin
      r_rr_ptr         <= w_next_ptr;
      r_cdb_valid      <= 1'b1;
      r_cdb_tag        <= fu_tag_i[int'(w_winner)*ROB_TAG_W +: ROB_TAG_W];
      r_cdb_preg       <= fu_preg_i[int'(w_winner)*PREG_W +: PREG_W];
      r_cdb_data       <= fu_data_i[int'(w_winner)*DATA_W +: DATA_W];
      r_cdb_mispredict <= fu_mispredict_i[w_winner];
    end else begin
      // Idle or flushed: tag/preg/data hold, only the qualifiers drop.
      r_cdb_valid      <= 1'b0;
      r_cdb_mispredict <= 1'b0;
    end
  end

  assign cdb_valid_o      = r_cdb_valid;
  assign cdb_tag_o        = r_cdb_tag;
  assign cdb_preg_o       = r_cdb_preg;
  assign cdb_data_o       = r_cdb_data;
  assign cdb_mispredict_o = r_cdb_mispredict;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: the stimulus process checks grants and
// queues expected broadcasts; a negedge monitor pops and compares the CDB.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [3:0]  fu_valid_i;
  logic [15:0] fu_tag_i;
  logic [23:0] fu_preg_i;
  logic [127:0] fu_data_i;
  logic [3:0]  fu_mispredict_i;
  logic [3:0]  fu_ready_o;
  logic        cdb_valid_o;
  logic [3:0]  cdb_tag_o;
  logic [5:0]  cdb_preg_o;
  logic [31:0] cdb_data_o;
  logic        cdb_mispredict_o;

  cdb_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .fu_valid_i       (fu_valid_i),
    .fu_tag_i         (fu_tag_i),
    .fu_preg_i        (fu_preg_i),
    .fu_data_i        (fu_data_i),
    .fu_mispredict_i  (fu_mispredict_i),
    .fu_ready_o       (fu_ready_o),
    .cdb_valid_o      (cdb_valid_o),
    .cdb_tag_o        (cdb_tag_o),
    .cdb_preg_o       (cdb_preg_o),
    .cdb_data_o       (cdb_data_o),
    .cdb_mispredict_o (cdb_mispredict_o)
  );

  always #5 clk = ~clk;

  logic [3:0]  tag  [4];
  logic [5:0]  preg [4];
  logic [31:0] data [4];
  logic        misp [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fu_tag_i[i*4 +: 4]        = tag[i];
      fu_preg_i[i*6 +: 6]       = preg[i];
      fu_data_i[i*32 +: 32]     = data[i];
      fu_mispredict_i[i]        = misp[i];
    end
  end

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [5:0]  preg;
    logic [31:0] data;
    logic        misp;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_fu(input int i, input logic [3:0] t, input logic [5:0] p,
                        input logic [31:0] d, input logic m);
    tag[i] = t; preg[i] = p; data[i] = d; misp[i] = m;
  endtask

  // Apply one cycle of inputs, check the combinational grant, queue the broadcast.
  task automatic step(input string name, input logic r, input logic f,
                      input logic [3:0] valid, input logic [3:0] exp_ready);
    exp_t e;
    rst = r; flush_i = f; fu_valid_i = valid;
    #1;
    check(name, 64'(fu_ready_o), 64'(exp_ready));
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        e.due = cyc + 1; e.tag = tag[i]; e.preg = preg[i]; e.data = data[i]; e.misp = misp[i];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("cdb_latency", 64'(cyc), 64'(e.due));
        check("cdb_valid", 64'(cdb_valid_o), 64'(1));
        check("cdb_tag", 64'(cdb_tag_o), 64'(e.tag));
        check("cdb_preg", 64'(cdb_preg_o), 64'(e.preg));
        check("cdb_data", 64'(cdb_data_o), 64'(e.data));
        check("cdb_misp", 64'(cdb_mispredict_o), 64'(e.misp));
      end else begin
        check("cdb_idle_valid", 64'(cdb_valid_o), 64'(0));
        check("cdb_idle_misp", 64'(cdb_mispredict_o), 64'(0));
      end
    end
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; fu_valid_i = 4'hF;
    for (int i = 0; i < 4; i++) set_fu(i, 4'(i + 1), 6'(10 + i), 32'h100 + 32'(i), 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held with every unit requesting: no grants, no broadcasts.
    step("reset_ready0", 1'b1, 1'b0, 4'b1111, 4'b0000);
    step("reset_ready1", 1'b1, 1'b0, 4'b1111, 4'b0000);

    // All-valid stream from rr_ptr=0: 0,1,2,3,0 back to back.
    step("stream_g0", 1'b0, 1'b0, 4'b1111, 4'b0001);
    step("stream_g1", 1'b0, 1'b0, 4'b1111, 4'b0010);
    step("stream_g2", 1'b0, 1'b0, 4'b1111, 4'b0100);
    step("stream_g3", 1'b0, 1'b0, 4'b1111, 4'b1000);
    step("stream_g4", 1'b0, 1'b0, 4'b1111, 4'b0001);

    // Single requester FU2 (rr_ptr=1) -> rr_ptr becomes 3.
    set_fu(2, 4'd5, 6'd17, 32'hDEAD, 1'b0);
    step("single_fu2", 1'b0, 1'b0, 4'b0100, 4'b0100);

    // Wrap from rr_ptr=3: FU3 first, then FU0, leaving rr_ptr=1.
    set_fu(0, 4'd6, 6'd20, 32'hA0A0_0000, 1'b0);
    set_fu(3, 4'd7, 6'd33, 32'h3333_3333, 1'b0);
    step("wrap_fu3", 1'b0, 1'b0, 4'b1001, 4'b1000);
    step("wrap_fu0", 1'b0, 1'b0, 4'b0001, 4'b0001);
    step("after_wrap", 1'b0, 1'b0, 4'b1111, 4'b0010);

    // Flush blocks FU1; after release it is granted (rr_ptr 2 -> winner 1).
    set_fu(1, 4'd11, 6'd41, 32'h1111_0001, 1'b0);
    step("flush_0", 1'b0, 1'b1, 4'b0010, 4'b0000);
    step("flush_1", 1'b0, 1'b1, 4'b0010, 4'b0000);
    step("flush_rel", 1'b0, 1'b0, 4'b0010, 4'b0010);
    step("idle_a", 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Broadcast registered just before a flush still appears; rr_ptr holds at 3.
    set_fu(2, 4'd12, 6'd42, 32'h2222_0002, 1'b0);
    step("pre_flush", 1'b0, 1'b0, 4'b0100, 4'b0100);
    step("flush_hold", 1'b0, 1'b1, 4'b1001, 4'b0000);
    step("flush_ptr", 1'b0, 1'b0, 4'b1001, 4'b1000);
    step("flush_fu0", 1'b0, 1'b0, 4'b0001, 4'b0001);

    // Mispredict pulse from FU1, then an idle cycle clears it.
    set_fu(1, 4'd9, 6'd50, 32'hBAD0_0009, 1'b1);
    step("misp_fu1", 1'b0, 1'b0, 4'b0010, 4'b0010);
    set_fu(1, 4'd9, 6'd50, 32'hBAD0_0009, 1'b0);
    step("misp_idle", 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Reset mid-operation: pointer returns to 0 (rr_ptr was 2 before FU0 grant).
    step("pre_rst", 1'b0, 1'b0, 4'b0001, 4'b0001);
    step("mid_rst", 1'b1, 1'b0, 4'b1111, 4'b0000);
    step("post_rst", 1'b0, 1'b0, 4'b1111, 4'b0001);
    step("tail0", 1'b0, 1'b0, 4'b0000, 4'b0000);
    step("tail1", 1'b0, 1'b0, 4'b0000, 4'b0000);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
